// File: rtl/spi_ram_arbiter.sv
// ---------------------------------------------------------------------------
// spi_ram_arbiter
//
// Purpose:
//    Sits between an SPI slave and a single-port RAM. Ten-bit SPI command
//    words are decoded into address loads, RAM writes and RAM reads. The one
//    RAM port is shared round-robin with a local host port. SPI read data is
//    returned on tx_data and held valid for TX_HOLD cycles, which gives the
//    slave time to shift it out on MISO.
//
// Ports:
//    clk, rst        clock (rising edge) and asynchronous active-high reset
//    rx_data/valid   SPI command word ([9:8] opcode, [7:0] payload) and strobe
//    tx_data/valid   SPI read data back to the slave, valid TX_HOLD cycles
//    host_*          level request port: req/we/addr/wdata in, ack/rdata out
//    mem_*           single-port RAM: en/we/addr/din out, dout in (1-cycle read)
//    spi_ovf         sticky flag, an SPI access was dropped while one pended
// ---------------------------------------------------------------------------
module spi_ram_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TX_HOLD   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9:0]           rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [7:0]           host_wdata,
   output logic                 host_ack,
   output logic [7:0]           host_rdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [7:0]           mem_din,
   input  logic [7:0]           mem_dout,
   output logic                 spi_ovf
);

   localparam int CNT_W = $clog2(TX_HOLD + 1);

   typedef enum logic [2:0] {
      IDLE,
      SPI_ACC,
      SPI_CAP,
      HOST_ACC,
      HOST_CAP
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
   logic                   pend_q, pend_d;
   logic                   pend_we_q, pend_we_d;
   logic [ADDR_SIZE-1:0]   pend_addr_q, pend_addr_d;
   logic [7:0]             pend_data_q, pend_data_d;
   logic                   spi_ovf_q, spi_ovf_d;
   logic                   last_spi_q, last_spi_d;
   logic                   host_we_q, host_we_d;
   logic [ADDR_SIZE-1:0]   host_addr_q, host_addr_d;
   logic [7:0]             host_wdata_q, host_wdata_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
   logic [7:0]             host_rdata_q, host_rdata_d;
   logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]             mem_din_q, mem_din_d;
   logic                   spi_wins;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         pend_q       <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         spi_ovf_q    <= 1'b0;
         last_spi_q   <= 1'b0;
         host_we_q    <= 1'b0;
         host_addr_q  <= '0;
         host_wdata_q <= '0;
         tx_data_q    <= '0;
         tx_cnt_q     <= '0;
         host_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         pend_q       <= pend_d;
         pend_we_q    <= pend_we_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         spi_ovf_q    <= spi_ovf_d;
         last_spi_q   <= last_spi_d;
         host_we_q    <= host_we_d;
         host_addr_q  <= host_addr_d;
         host_wdata_q <= host_wdata_d;
         tx_data_q    <= tx_data_d;
         tx_cnt_q     <= tx_cnt_d;
         host_rdata_q <= host_rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
      end
   end

   // RAM-side and host-side outputs are decoded from the current state.
   // Outside the ACC states the address/data buses replay their last value.
   // host_rdata bypasses mem_dout in HOST_CAP so the data lines up with ack.
   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = mem_addr_q;
      mem_din    = mem_din_q;
      host_ack   = 1'b0;
      host_rdata = host_rdata_q;
      case (state_q)
         SPI_ACC: begin
            mem_en   = 1'b1;
            mem_we   = pend_we_q;
            mem_addr = pend_addr_q;
            mem_din  = pend_data_q;
         end
         HOST_ACC: begin
            mem_en   = 1'b1;
            mem_we   = host_we_q;
            mem_addr = host_addr_q;
            mem_din  = host_wdata_q;
            host_ack = host_we_q;
         end
         HOST_CAP: begin
            host_ack   = 1'b1;
            host_rdata = mem_dout;
         end
         default: ;
      endcase
   end

   // SPI wins arbitration when it alone is pending, or on a tie when the
   // host had the previous grant.
   assign spi_wins = pend_q && (!host_req || !last_spi_q);

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      rd_addr_d    = rd_addr_q;
      pend_d       = pend_q;
      pend_we_d    = pend_we_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      spi_ovf_d    = spi_ovf_q;
      last_spi_d   = last_spi_q;
      host_we_d    = host_we_q;
      host_addr_d  = host_addr_q;
      host_wdata_d = host_wdata_q;
      tx_data_d    = tx_data_q;
      tx_cnt_d     = (tx_cnt_q != '0) ? tx_cnt_q - CNT_W'(1) : '0;
      host_rdata_d = host_rdata_q;
      mem_addr_d   = mem_addr;
      mem_din_d    = mem_din;

      case (state_q)
         IDLE: begin
            if (spi_wins) begin
               state_d    = SPI_ACC;
               last_spi_d = 1'b1;
            end else if (host_req) begin
               state_d      = HOST_ACC;
               last_spi_d   = 1'b0;
               host_we_d    = host_we;
               host_addr_d  = host_addr;
               host_wdata_d = host_wdata;
            end
         end
         SPI_ACC: begin
            pend_d  = 1'b0;
            state_d = pend_we_q ? IDLE : SPI_CAP;
         end
         SPI_CAP: begin
            tx_data_d = mem_dout;
            tx_cnt_d  = CNT_W'(TX_HOLD);
            state_d   = IDLE;
         end
         HOST_ACC: begin
            state_d = host_we_q ? IDLE : HOST_CAP;
         end
         HOST_CAP: begin
            host_rdata_d = mem_dout;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Command decode is independent of the FSM. pend_q is still set during
      // SPI_ACC, so a command arriving in that cycle counts as an overflow.
      if (rx_valid) begin
         case (rx_data[9:8])
            2'b00: wr_addr_d = rx_data[ADDR_SIZE-1:0];
            2'b10: rd_addr_d = rx_data[ADDR_SIZE-1:0];
            2'b01: begin
               if (!pend_q) begin
                  pend_d      = 1'b1;
                  pend_we_d   = 1'b1;
                  pend_addr_d = wr_addr_q;
                  pend_data_d = rx_data[7:0];
               end else begin
                  spi_ovf_d = 1'b1;
               end
            end
            default: begin
               if (!pend_q) begin
                  pend_d      = 1'b1;
                  pend_we_d   = 1'b0;
                  pend_addr_d = rd_addr_q;
               end else begin
                  spi_ovf_d = 1'b1;
               end
            end
         endcase
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = (tx_cnt_q != '0);
   assign spi_ovf  = spi_ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed testbench for spi_ram_arbiter with a small behavioural RAM.
module tb_spi_ram_arbiter;

   logic       clk;
   logic       rst;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       host_req;
   logic       host_we;
   logic [7:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_ack;
   logic [7:0] host_rdata;
   logic       mem_en;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_din;
   logic [7:0] mem_dout;
   logic       spi_ovf;

   logic [7:0] ram [0:255];

   int compareCount = 0;
   int failCount    = 0;

   spi_ram_arbiter #(.ADDR_SIZE(8), .TX_HOLD(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .spi_ovf    (spi_ovf)
   );

   // 100 MHz-style free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port RAM model: write on enable+we, registered read otherwise
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_din;
         else        mem_dout <= ram[mem_addr];
      end
   end

   // Safety net so the bench can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and land 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a one-cycle SPI command pulse; returns in the cycle after the pulse
   task automatic applyStimulus(input logic [9:0] word);
      rx_data  = word;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   // Compare one observed value against its expected value and count it
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Set up a host request in the current cycle
   task automatic hostDrive(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      host_req   = 1'b1;
      host_we    = we;
      host_addr  = addr;
      host_wdata = wdata;
   endtask

   // Main directed sequence
   initial begin
      int cnt;
      int cnt2;
      rst        = 1'b1;
      rx_data    = '0;
      rx_valid   = 1'b0;
      host_req   = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      repeat (3) @(posedge clk);
      #1;

      checkOutput("rst_mem_en",     mem_en,     0);
      checkOutput("rst_mem_we",     mem_we,     0);
      checkOutput("rst_mem_addr",   mem_addr,   0);
      checkOutput("rst_mem_din",    mem_din,    0);
      checkOutput("rst_tx_valid",   tx_valid,   0);
      checkOutput("rst_tx_data",    tx_data,    0);
      checkOutput("rst_host_ack",   host_ack,   0);
      checkOutput("rst_host_rdata", host_rdata, 0);
      checkOutput("rst_spi_ovf",    spi_ovf,    0);
      rst = 1'b0;
      tick();

      // First tie after reset: SPI write to wr_addr=0 wins, host follows
      applyStimulus(10'h1B4);
      hostDrive(1'b1, 8'h20, 8'h11);
      tick();
      checkOutput("tieA_spi_en",   mem_en,   1);
      checkOutput("tieA_spi_addr", mem_addr, 8'h00);
      checkOutput("tieA_spi_din",  mem_din,  8'hB4);
      checkOutput("tieA_spi_ack",  host_ack, 0);
      tick();
      checkOutput("tieA_idle_en",  mem_en,   0);
      tick();
      checkOutput("tieA_host_ack",  host_ack, 1);
      checkOutput("tieA_host_addr", mem_addr, 8'h20);
      checkOutput("tieA_host_din",  mem_din,  8'h11);
      host_req = 1'b0;
      tick();

      // SPI-only write leaves the last grant with SPI
      applyStimulus(10'h1C3);
      tick();
      checkOutput("solo_din", mem_din, 8'hC3);
      tick();

      // Second tie: host wins because SPI had the last grant
      applyStimulus(10'h1D2);
      hostDrive(1'b1, 8'h21, 8'h22);
      tick();
      checkOutput("tieB_host_ack",  host_ack, 1);
      checkOutput("tieB_host_addr", mem_addr, 8'h21);
      host_req = 1'b0;
      tick();
      checkOutput("tieB_idle_en", mem_en, 0);
      tick();
      checkOutput("tieB_spi_en",  mem_en,  1);
      checkOutput("tieB_spi_din", mem_din, 8'hD2);
      tick();

      // Address load then write: one-cycle write two cycles after the pulse
      applyStimulus(10'h005);
      repeat (3) tick();
      applyStimulus(10'h1A5);
      checkOutput("wr_early_en", mem_en, 0);
      tick();
      checkOutput("wr_en",   mem_en,   1);
      checkOutput("wr_we",   mem_we,   1);
      checkOutput("wr_addr", mem_addr, 8'h05);
      checkOutput("wr_din",  mem_din,  8'hA5);
      tick();
      checkOutput("wr_end_en",    mem_en,   0);
      checkOutput("wr_hold_addr", mem_addr, 8'h05);

      // Preload RAM[0x33]=0x5C through the host port
      hostDrive(1'b1, 8'h33, 8'h5C);
      tick();
      checkOutput("pre_ack", host_ack, 1);
      host_req = 1'b0;
      tick();

      // Host write 0x77 to 0x10, acked in the grant-following cycle
      hostDrive(1'b1, 8'h10, 8'h77);
      tick();
      checkOutput("hw_en",   mem_en,   1);
      checkOutput("hw_we",   mem_we,   1);
      checkOutput("hw_ack",  host_ack, 1);
      checkOutput("hw_addr", mem_addr, 8'h10);
      host_req = 1'b0;
      tick();
      checkOutput("hw_ack_end", host_ack, 0);

      // Host read of 0x10: ack and data one cycle after mem_en
      hostDrive(1'b0, 8'h10, 8'h00);
      tick();
      checkOutput("hr_en",  mem_en,   1);
      checkOutput("hr_we",  mem_we,   0);
      checkOutput("hr_ack_early", host_ack, 0);
      host_req = 1'b0;
      tick();
      checkOutput("hr_ack",   host_ack,   1);
      checkOutput("hr_rdata", host_rdata, 8'h77);
      tick();
      checkOutput("hr_ack_end",   host_ack,   0);
      checkOutput("hr_rdata_hold", host_rdata, 8'h77);

      // SPI read of 0x33: tx_valid from pulse+4 for exactly 8 cycles
      applyStimulus(10'h233);
      tick();
      applyStimulus(10'h300);
      tick();
      checkOutput("sr_en",   mem_en,   1);
      checkOutput("sr_we",   mem_we,   0);
      checkOutput("sr_addr", mem_addr, 8'h33);
      tick();
      checkOutput("sr_txv_early", tx_valid, 0);
      tick();
      checkOutput("sr_txv",  tx_valid, 1);
      checkOutput("sr_txd",  tx_data,  8'h5C);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx_valid) cnt++;
         tick();
      end
      checkOutput("sr_txv_len", cnt, 8);

      // Two reads back to back: second is dropped, overflow sticks
      rx_data  = 10'h300;
      rx_valid = 1'b1;
      tick();
      tick();
      rx_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (mem_en) cnt++;
         tick();
      end
      checkOutput("ovf_reads", cnt, 1);
      checkOutput("ovf_set",   spi_ovf, 1);
      repeat (5) tick();
      checkOutput("ovf_sticky", spi_ovf, 1);

      // Reset in the middle of an SPI read access
      applyStimulus(10'h300);
      tick();
      checkOutput("ra_en_before", mem_en, 1);
      rst = 1'b1;
      #1;
      checkOutput("ra_mem_en",     mem_en,     0);
      checkOutput("ra_mem_we",     mem_we,     0);
      checkOutput("ra_mem_addr",   mem_addr,   0);
      checkOutput("ra_mem_din",    mem_din,    0);
      checkOutput("ra_tx_valid",   tx_valid,   0);
      checkOutput("ra_tx_data",    tx_data,    0);
      checkOutput("ra_host_ack",   host_ack,   0);
      checkOutput("ra_host_rdata", host_rdata, 0);
      checkOutput("ra_spi_ovf",    spi_ovf,    0);
      tick();
      rst = 1'b0;
      cnt  = 0;
      cnt2 = 0;
      for (int i = 0; i < 12; i++) begin
         if (tx_valid) cnt++;
         if (mem_en)   cnt2++;
         tick();
      end
      checkOutput("ra_txv_never", cnt,  0);
      checkOutput("ra_en_never",  cnt2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
